// File: rtl/mips_pkg.sv
// Shared constants for the MIPS front end: bus widths, NOP encoding, fetch FSM states.
package mips_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ST_W   = 3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_REQ   = 3'd1;
    localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [ST_W-1:0] ST_VALID = 3'd3;
    localparam logic [ST_W-1:0] ST_DRAIN = 3'd4;

endpackage

// File: rtl/ifetch_stage_if.sv
// Instruction-memory req/ack read channel between the fetch stage and imem.
interface ifetch_stage_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: one imem read per PC update, IR + PC+4 for decode.
// Optional ack watchdog enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_stage #(
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
    parameter int unsigned DATA_W = mips_pkg::DATA_W
`ifdef IFETCH_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 15
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    input  logic              stall,
    input  logic              flush,
    ifetch_stage_if.master    imem,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              instr_valid,
    output logic              fetch_busy,
    output logic              misalign_err,
    output logic              timeout_err
);
    import mips_pkg::*;

    logic [ST_W-1:0]   state_q, state_d;
    logic              req_q, req_d, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d, plus4_d;
    logic [DATA_W-1:0] instr_d;
    logic              ivalid_d, mis_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;
`ifdef IFETCH_TIMEOUT_EN
    logic [3:0]        cnt_q, cnt_d;
    logic              tout_q, tout_d;
    assign timeout_err = tout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        plus4_d     = pc_plus4;
        instr_d     = instr_out;
        ivalid_d    = instr_valid;
        mis_d       = misalign_err;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        issue       = 1'b0;
        issue_addr  = pc_in;

        if (flush) begin
            pend_d   = 1'b0;
            ivalid_d = 1'b0;
            instr_d  = DATA_W'(NOP_INSTR);
            case (state_q)
                ST_REQ, ST_WAIT, ST_DRAIN: state_d = imem.imem_ack ? ST_IDLE : ST_DRAIN;
                default:                   state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE, ST_VALID: begin
                    if (!stall && (pc_valid || pend_q)) begin
                        issue      = 1'b1;
                        issue_addr = pc_valid ? pc_in : pend_addr_q;
                        pend_d     = 1'b0;
                    end else if (pc_valid) begin
                        pend_d      = 1'b1;
                        pend_addr_d = pc_in;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (pc_valid) begin
                        pend_d      = 1'b1;
                        pend_addr_d = pc_in;
                    end
                    if (imem.imem_ack) begin
                        instr_d  = imem.imem_rdata;
                        ivalid_d = 1'b1;
                        state_d  = ST_VALID;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (pc_valid) begin
                        pend_d      = 1'b1;
                        pend_addr_d = pc_in;
                    end
                    if (imem.imem_ack) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (issue) begin
                addr_d   = issue_addr;
                plus4_d  = issue_addr + ADDR_W'(4);
                ivalid_d = 1'b0;
                mis_d    = misalign_err | (|issue_addr[1:0]);
                state_d  = ST_REQ;
            end
        end

`ifdef IFETCH_TIMEOUT_EN
        // Watchdog: abandon the read and retire a NOP so the pipeline keeps moving
        cnt_d  = '0;
        tout_d = tout_q;
        if (fetch_busy && !imem.imem_ack) begin
            if (cnt_q == 4'(TIMEOUT - 1)) begin
                tout_d = 1'b1;
                if (flush || state_q == ST_DRAIN) begin
                    state_d = ST_IDLE;
                end else begin
                    instr_d  = DATA_W'(NOP_INSTR);
                    ivalid_d = 1'b1;
                    state_d  = ST_VALID;
                end
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
`endif

        busy_d = (state_d == ST_REQ) || (state_d == ST_WAIT) || (state_d == ST_DRAIN);
        req_d  = busy_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            fetch_busy   <= 1'b0;
            addr_q       <= '0;
            pc_plus4     <= '0;
            instr_out    <= DATA_W'(NOP_INSTR);
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
`ifdef IFETCH_TIMEOUT_EN
            cnt_q        <= '0;
            tout_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            fetch_busy   <= busy_d;
            addr_q       <= addr_d;
            pc_plus4     <= plus4_d;
            instr_out    <= instr_d;
            instr_valid  <= ivalid_d;
            misalign_err <= mis_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
`ifdef IFETCH_TIMEOUT_EN
            cnt_q        <= cnt_d;
            tout_q       <= tout_d;
`endif
        end
    end

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction fetch stage directly downstream of the multi-cycle program counter register.
- On each PC update it issues one req/ack read to instruction memory and latches the returned word into the instruction register (IR).
- Also produces PC+4 for next-PC logic.
- Presents a stable instruction and valid flag to decode until the next fetch or a flush.

Parameters:
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction word width.
- TIMEOUT, 15, max cycles waiting for imem_ack; used only with IFETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_in  in  ADDR_W  current PC from the PC register.
- pc_valid  in  1  one-cycle pulse: pc_in has just been updated.
- stall  in  1  decode not ready; hold IR.
- flush  in  1  discard the current and pending fetch.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_W  read address; stable while imem_req=1.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  DATA_W  instruction word.
- instr_out  out  DATA_W  instruction register.
- pc_plus4  out  ADDR_W  fetched address + 4.
- instr_valid  out  1  instr_out holds a valid instruction.
- fetch_busy  out  1  high in REQ/WAIT/DRAIN.
- misalign_err  out  1  sticky: fetched address had [1:0]!=0.
- timeout_err  out  1  sticky watchdog flag; constant 0 when the feature is disabled.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - imem_req=0, imem_addr=0, instr_out=32'h0 (NOP), pc_plus4=0.
  - instr_valid=0, misalign_err=0, timeout_err=0.
  - pending flag cleared.
- States: IDLE, REQ, WAIT, VALID, DRAIN.
- IDLE/VALID + pc_valid (with stall=0):
  - Latch imem_addr=pc_in, pc_plus4=pc_in+4 (mod 2^ADDR_W; 32'hFFFFFFFC -> 0).
  - instr_valid<=0, go to REQ.
- REQ:
  - imem_req=1.
  - imem_ack same cycle: instr_out<=imem_rdata, instr_valid<=1, go to VALID. Minimum latency pc_valid -> instr_valid is 2 cycles.
  - Otherwise go to WAIT.
- WAIT: imem_req held 1 and imem_addr stable until imem_ack. On ack: drop req, latch IR, go to VALID.
- VALID:
  - instr_out and instr_valid are held.
  - stall=1: IR is frozen; a pc_valid arriving now is recorded as pending.
  - A pending fetch (or a new pc_valid) starts once stall=0.
- pc_valid during REQ/WAIT: recorded in a one-deep pending register (address + flag). It is issued the cycle after VALID is entered, provided stall=0. A second pc_valid while pending overwrites the pending address.
- Misalignment: the fetch proceeds normally; misalign_err is set when the request issues with imem_addr[1:0]!=0.
- flush (highest priority after reset):
  - Pending cleared, instr_valid<=0, instr_out<=0.
  - From REQ/WAIT: go to DRAIN. imem_req stays 1 until ack; the returned data is discarded; then go to IDLE.
  - From IDLE/VALID: go to IDLE.
- flush and pc_valid in the same cycle: flush wins and pc_valid is ignored.
- flush and imem_ack in the same cycle (REQ/WAIT): data discarded, go directly to IDLE.
- Reset mid-transaction: immediate return to IDLE with imem_req=0; memory must tolerate the abandoned request.

Optional Feature:
- Macro IFETCH_TIMEOUT_EN.
- Defined:
  - A 4-bit counter runs in REQ/WAIT/DRAIN and clears on ack.
  - When it reaches TIMEOUT, the request is abandoned: imem_req<=0, timeout_err<=1 (sticky until reset).
  - instr_out<=0, instr_valid<=1, so the NOP retires and the pipeline proceeds.
  - Go to VALID (or to IDLE if the state was DRAIN).
- Undefined: no counter; WAIT lasts indefinitely; timeout_err tied 0.

Decomposition:
- Shared package mips_pkg:
  - ADDR_W/DATA_W constants.
  - NOP_INSTR=32'h0000_0000.
  - fetch state enum (IDLE, REQ, WAIT, VALID, DRAIN).
- No sub-module needed. The optional watchdog is small enough to stay inline rather than be split out as ifetch_watchdog.

Test Plan:
- Reset release, pc_valid with pc_in=0x0000_0000, ack on the REQ cycle returning 0x2008_0005 -> instr_out=0x2008_0005, pc_plus4=0x4, instr_valid=1 two cycles after pc_valid.
- pc_in=0x0000_0040 with ack delayed 5 cycles -> imem_req high 6 cycles, imem_addr stable at 0x40, fetch_busy=1 throughout, IR latched on the ack edge.
- pc_valid(0x44) during WAIT of fetch 0x40 -> after 0x40 completes, 0x44 issues the next cycle; both instructions observed in order.
- flush during WAIT -> DRAIN; req held until ack; ack data 0xDEAD_BEEF never appears on instr_out; instr_valid=0; return to IDLE.
- pc_in=0x0000_0042 -> misalign_err=1 and stays set until rst_n low; pc_in=0xFFFF_FFFC -> pc_plus4=0x0.
- IFETCH_TIMEOUT_EN defined, no ack -> after 15 cycles imem_req=0, timeout_err=1, instr_out=0, instr_valid=1; without the macro, req is still high at cycle 100.
